// File: rtl/sap_pkg.sv
// Shared definitions for the SAP fetch front end: FSM state encoding and
// default datapath widths.
package sap_pkg;

  localparam int SAP_ADDR_W   = 4;
  localparam int SAP_DATA_W   = 8;
  localparam int SAP_OPCODE_W = 4;

  typedef enum logic [1:0] {
    ADDR = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/sap_pc.sv
// Program counter: synchronous clear, load (takes priority) and increment.
// The increment wraps modulo 2^ADDR_W.
module sap_pc #(
  parameter int                ADDR_W    = 4,
  parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // Next PC: a jump load beats the post-request increment.
  always_comb begin
    pc_d = pc_q;
    if (load_i)
      pc_d = load_val_i;
    else if (inc_i)
      pc_d = pc_q + ADDR_W'(1);
  end

  // PC register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr_i)
      pc_q <= RESET_VAL;
    else
      pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/sap_fetch_unit.sv
// SAP instruction-fetch front end: PC, MAR and IR around a request/valid
// memory handshake, presenting opcode/operand to the sequencer via
// valid/ready. The sequencer may jump or halt on the accept cycle.
module sap_fetch_unit
  import sap_pkg::*;
#(
  parameter int                ADDR_W   = SAP_ADDR_W,
  parameter int                DATA_W   = SAP_DATA_W,
  parameter int                OPCODE_W = SAP_OPCODE_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       clr,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_rvalid,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [OPCODE_W-1:0]        opcode,
  output logic [DATA_W-OPCODE_W-1:0] operand,
  input  logic                       jump_en,
  input  logic [ADDR_W-1:0]          jump_addr,
  input  logic                       halt,
  output logic [ADDR_W-1:0]          pc_value,
  output logic                       halted
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  // Set for exactly the first REQ cycle so the PC bumps once per fetch,
  // no matter how many cycles the memory keeps us waiting.
  logic              first_q, first_d;
  logic              pc_inc, pc_load;
  logic [ADDR_W-1:0] pc;

  sap_pc #(
    .ADDR_W    (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .clr_i      (clr),
    .inc_i      (pc_inc),
    .load_i     (pc_load),
    .load_val_i (jump_addr),
    .pc_o       (pc)
  );

  // Next-state, datapath-next and handshake outputs of the fetch FSM.
  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    first_d     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      ADDR: begin
        mar_d   = pc;
        first_d = 1'b1;
        state_d = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        pc_inc  = first_q;
        // Response only counts here; stray rvalid elsewhere never touches IR.
        if (mem_rvalid) begin
          ir_d    = mem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        // jump/halt are only meaningful on the accept cycle.
        if (instr_ready) begin
          if (halt) begin
            state_d = HALT;
          end else begin
            pc_load = jump_en;
            state_d = ADDR;
          end
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = ADDR;
    endcase
  end

  // State, MAR, IR and first-cycle flag; clr abandons any outstanding read.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ADDR;
      mar_q   <= '0;
      ir_q    <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      first_q <= first_d;
    end
  end

  assign mem_addr = mar_q;
  assign opcode   = ir_q[DATA_W-1 -: OPCODE_W];
  assign operand  = ir_q[DATA_W-OPCODE_W-1:0];
  assign pc_value = pc;

endmodule

// File: tb/tb_sap_fetch_unit.sv
// Directed bench for sap_fetch_unit: default 8-bit build with a
// variable-latency ROM, plus a 16-bit / 6-bit-opcode build with RESET_PC=5.
module tb_sap_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default build ----------------
  logic       clr, mem_req, mem_rvalid, instr_valid, instr_ready;
  logic       jump_en, halt, halted;
  logic [3:0] mem_addr, opcode, operand, jump_addr, pc_value;
  logic [7:0] mem_rdata;
  logic [7:0] rom [16];
  int         req_cycles, wcnt;
  logic       stray;

  sap_fetch_unit dut (
    .clk         (clk),
    .clr         (clr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .operand     (operand),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halt        (halt),
    .pc_value    (pc_value),
    .halted      (halted)
  );

  // Memory model: response on the req_cycles-th cycle of a request,
  // plus an injectable stray rvalid.
  assign mem_rdata  = rom[mem_addr];
  assign mem_rvalid = (mem_req && (wcnt == req_cycles - 1)) || stray;
  always_ff @(posedge clk) begin
    if (!mem_req || mem_rvalid) wcnt <= 0;
    else                        wcnt <= wcnt + 1;
  end

  // ---------------- wide build ----------------
  logic        clr2, mem_req2, instr_valid2, halted2;
  logic [3:0]  mem_addr2, pc2;
  logic [15:0] mem_rdata2;
  logic [5:0]  opcode2;
  logic [9:0]  operand2;
  logic [15:0] rom2 [16];

  sap_fetch_unit #(
    .ADDR_W   (4),
    .DATA_W   (16),
    .OPCODE_W (6),
    .RESET_PC (4'd5)
  ) dut2 (
    .clk         (clk),
    .clr         (clr2),
    .mem_req     (mem_req2),
    .mem_addr    (mem_addr2),
    .mem_rdata   (mem_rdata2),
    .mem_rvalid  (mem_req2),
    .instr_valid (instr_valid2),
    .instr_ready (1'b1),
    .opcode      (opcode2),
    .operand     (operand2),
    .jump_en     (1'b0),
    .jump_addr   (4'd0),
    .halt        (1'b0),
    .pc_value    (pc2),
    .halted      (halted2)
  );
  assign mem_rdata2 = rom2[mem_addr2];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Hand-derived expectations
  logic [3:0]  s1_op  [3] = '{4'h1, 4'h2, 4'h3};
  logic [3:0]  s1_opd [3] = '{4'hA, 4'hB, 4'hC};
  logic [5:0]  w_op   [3] = '{6'h2A, 6'h04, 6'h3F};
  logic [9:0]  w_opd  [3] = '{10'h3CD, 10'h234, 10'h3FF};
  logic [3:0]  j_addr [3] = '{4'hE, 4'hF, 4'h0};
  logic [3:0]  j_op   [3] = '{4'h5, 4'h6, 4'h1};
  logic [3:0]  j_opd  [3] = '{4'hE, 4'hF, 4'hA};
  logic [3:0]  j_pc   [3] = '{4'hF, 4'h0, 4'h1};

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom[i]  = 8'h00;
      rom2[i] = 16'h0000;
    end
    rom[0]  = 8'h1A; rom[1]  = 8'h2B; rom[2]  = 8'h3C; rom[3] = 8'h4D;
    rom[14] = 8'h5E; rom[15] = 8'h6F;
    rom2[5] = 16'hABCD; rom2[6] = 16'h1234; rom2[7] = 16'hFFFF;

    clr = 1'b1; clr2 = 1'b1; instr_ready = 1'b1; jump_en = 1'b0; halt = 1'b0;
    jump_addr = 4'h0; req_cycles = 1; stray = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_pc", pc_value, 4'h0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_addr", mem_addr, 4'h0);
    chk("rst_op", {opcode, operand}, 8'h00);
    chk("rst_pc2", pc2, 4'd5);
    chk("rst_addr2", mem_addr2, 4'd0);
    chk("rst_halted2", halted2, 1'b0);
    chk("rst_valid2", instr_valid2, 1'b0);

    // Zero-latency fetch of three words, both builds
    clr = 1'b0; clr2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("s1_req", mem_req, 1'b1);
      chk("s1_addr", mem_addr, k);
      chk("s1_valid_lo", instr_valid, 1'b0);
      chk("w_req", mem_req2, 1'b1);
      chk("w_addr", mem_addr2, 5 + k);
      tick();
      chk("s1_valid", instr_valid, 1'b1);
      chk("s1_opcode", opcode, s1_op[k]);
      chk("s1_operand", operand, s1_opd[k]);
      chk("s1_pc", pc_value, k + 1);
      chk("w_valid", instr_valid2, 1'b1);
      chk("w_opcode", opcode2, w_op[k]);
      chk("w_operand", operand2, w_opd[k]);
      chk("w_pc", pc2, 6 + k);
      tick();
      chk("s1_addr_phase", instr_valid, 1'b0);
    end

    // Four-cycle memory latency
    req_cycles = 4;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lat_req", mem_req, 1'b1);
      chk("lat_addr", mem_addr, 4'h3);
      chk("lat_pc", pc_value, (i == 0) ? 4'h3 : 4'h4);
      chk("lat_ir_old", opcode, 4'h3);
      chk("lat_valid", instr_valid, 1'b0);
    end
    tick();
    chk("lat_valid_hi", instr_valid, 1'b1);
    chk("lat_ir_new", {opcode, operand}, 8'h4D);
    req_cycles = 1;

    // Ready stall for five cycles with an ignored jump pulse
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_ir", {opcode, operand}, 8'h4D);
      chk("stall_req", mem_req, 1'b0);
      chk("stall_pc", pc_value, 4'h4);
      if (i == 0) begin jump_en = 1'b1; jump_addr = 4'h9; end
      if (i == 1) jump_en = 1'b0;
    end

    // Accept with a jump to 0xE, then wrap through 0xF to 0x0
    instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 4'hE;
    tick();
    chk("jmp_pc", pc_value, 4'hE);
    chk("jmp_valid", instr_valid, 1'b0);
    jump_en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("jmp_req", mem_req, 1'b1);
      chk("jmp_addr", mem_addr, j_addr[j]);
      tick();
      chk("jmp_opcode", opcode, j_op[j]);
      chk("jmp_operand", operand, j_opd[j]);
      chk("jmp_pc_next", pc_value, j_pc[j]);
      if (j < 2) tick();
    end

    // Halt together with jump: halt wins, unit freezes
    halt = 1'b1; jump_en = 1'b1; jump_addr = 4'h7;
    tick();
    halt = 1'b0; jump_en = 1'b0;
    chk("halt_halted", halted, 1'b1);
    chk("halt_valid", instr_valid, 1'b0);
    chk("halt_pc", pc_value, 4'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_req", mem_req, 1'b0);
      chk("halt_pc_frozen", pc_value, 4'h1);
      chk("halt_stays", halted, 1'b1);
    end

    // One-cycle clr restarts fetch from RESET_PC
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("rst2_pc", pc_value, 4'h0);
    chk("rst2_halted", halted, 1'b0);
    chk("rst2_req", mem_req, 1'b0);
    tick();
    chk("rst2_req_hi", mem_req, 1'b1);
    chk("rst2_addr", mem_addr, 4'h0);
    tick();
    chk("rst2_ir", {opcode, operand}, 8'h1A);
    chk("rst2_pc_inc", pc_value, 4'h1);
    req_cycles = 3;
    tick();

    // clr mid-REQ; the late response lands while in ADDR and is ignored
    tick();
    chk("abn_req", mem_req, 1'b1);
    chk("abn_addr", mem_addr, 4'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0; stray = 1'b1;
    chk("abn_ir_clr", {opcode, operand}, 8'h00);
    chk("abn_pc", pc_value, 4'h0);
    chk("abn_req_lo", mem_req, 1'b0);
    chk("abn_valid", instr_valid, 1'b0);
    tick();
    stray = 1'b0;
    chk("abn_ir_kept", {opcode, operand}, 8'h00);
    chk("abn_readdr", mem_addr, 4'h0);
    chk("abn_req_again", mem_req, 1'b1);
    tick(); tick();
    chk("abn_wait", mem_req, 1'b1);
    tick();
    chk("abn_valid_hi", instr_valid, 1'b1);
    chk("abn_ir_new", {opcode, operand}, 8'h1A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sap_fetch_unit.md
Name: sap_fetch_unit

Overview:
Parametrised instruction-fetch front end for the SAP core. It combines the program counter, MAR and instruction register with a request/valid memory handshake, so program memory may have any read latency. It splits each fetched word into opcode and operand and offers them to the control sequencer through a valid/ready handshake. The sequencer can redirect the PC (jump) or stop fetching (halt).

Parameters:
ADDR_W, 4, PC/MAR/memory address width (1..16)
DATA_W, 8, memory word and IR width
OPCODE_W, 4, upper IR bits forming the opcode; operand is the lower DATA_W-OPCODE_W bits (OPCODE_W < DATA_W)
RESET_PC, 0, PC value after reset (ADDR_W bits)

Ports:
clk  in  1  clock, rising edge
clr  in  1  synchronous active-high reset
mem_req  out  1  read request, held high until the word returns
mem_addr  out  ADDR_W  MAR contents, stable while mem_req is high
mem_rdata  in  DATA_W  read data, valid when mem_rvalid is high
mem_rvalid  in  1  read data valid; ignored unless mem_req is high
instr_valid  out  1  IR holds an instruction not yet accepted
instr_ready  in  1  sequencer accepts the instruction
opcode  out  OPCODE_W  IR[DATA_W-1 : DATA_W-OPCODE_W]
operand  out  DATA_W-OPCODE_W  IR[DATA_W-OPCODE_W-1 : 0]
jump_en  in  1  redirect the PC; sampled only on the accept cycle
jump_addr  in  ADDR_W  jump target
halt  in  1  stop fetching; sampled only on the accept cycle
pc_value  out  ADDR_W  current PC, for debug/output
halted  out  1  unit is in HALT

Behaviour:
- One clock. Reset is synchronous and active-high on clr. clr has priority over every other input in every state.
- Reset values: PC=RESET_PC, MAR=0, IR=0, state=ADDR, mem_req=0, instr_valid=0, halted=0.
- States: ADDR, REQ, HOLD, HALT.
- ADDR: MAR<=PC; next state REQ.
- REQ:
  - mem_req=1 and mem_addr=MAR.
  - On the first cycle in REQ, PC<=PC+1, wrapping modulo 2^ADDR_W (all-ones goes to 0). The PC increments exactly once per fetch, however long the wait.
  - When mem_rvalid=1: IR<=mem_rdata; next state HOLD.
  - Zero-latency memory (rvalid in the same cycle as req) is legal. REQ then lasts 1 cycle.
- HOLD:
  - instr_valid=1; mem_req=0. IR, opcode and operand stay stable until accepted.
  - Accept happens when instr_ready=1:
    - halt=1: next state HALT. halt wins over jump_en.
    - otherwise jump_en=1: PC<=jump_addr; next state ADDR.
    - otherwise: next state ADDR, PC unchanged (already incremented).
  - jump_en and halt are ignored in every cycle that is not an accept.
- HALT: halted=1; instr_valid=0; mem_req=0. The unit stays here until clr.
- Throughput: 3 cycles per instruction with zero-latency memory and instr_ready tied high (ADDR, REQ, HOLD). Each extra memory wait cycle or ready stall adds 1 cycle.
- First instr_valid appears 2 cycles after clr deasserts, with zero-latency memory.
- mem_rvalid outside REQ is ignored. A late or stray response must not modify IR.
- clr during REQ abandons the outstanding read. The next request's address is RESET_PC. The memory model must tolerate an abandoned request.
- pc_value equals the PC register at all times.

Decomposition:
- Shared package sap_pkg: state encoding enum fetch_state_t {ADDR, REQ, HOLD, HALT}; default width constants SAP_ADDR_W=4, SAP_DATA_W=8, SAP_OPCODE_W=4.
- One natural sub-module: sap_pc, a parametrised ADDR_W counter with sync clr, inc and load/load_val (load has priority over inc). Instantiated once.
- MAR, IR and the FSM are inline.

Test Plan:
- Zero-latency ROM holding 0x1A,0x2B,0x3C at addresses 0..2; instr_ready=1 -> mem_addr sequence 0,1,2; opcode/operand (1,A),(2,B),(3,C); instr_valid pulses every 3rd cycle; first pulse 2 cycles after clr deasserts.
- Memory latency 4 cycles -> mem_req held 4 cycles with mem_addr stable; PC increments exactly once; IR updates only on the rvalid cycle.
- instr_ready low for 5 cycles in HOLD -> opcode/operand stable; no mem_req; jump_en=1 pulsed during the stall is ignored.
- Accept with jump_en=1 and jump_addr=0xE -> next mem_addr=0xE, then 0xF, then 0x0 (wrap check).
- Accept with halt=1 and jump_en=1 together -> halted=1; mem_req stays 0 for 20 cycles; pc_value frozen. Then clr=1 for one cycle -> PC=RESET_PC and fetch restarts.
- clr asserted mid-REQ with a response arriving one cycle later -> IR remains 0; state ADDR; next request to RESET_PC; DATA_W=16, OPCODE_W=6 build repeats scenario 1 with correct field split.
